// File: rtl/drm_pkg.sv
// drm_pkg: FSM state encoding and helper functions shared by the DRM stream reader
package drm_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/drm_rd_skid_fifo.sv
// drm_rd_skid_fifo: small register FIFO that absorbs RAM read latency under stream backpressure
module drm_rd_skid_fifo import drm_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? ((wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = pop ? ((rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/drm_stream_reader.sv
// drm_stream_reader: issues burst reads to a DRM read port and streams the words out with valid/ready/last
module drm_stream_reader import drm_pkg::*; #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  localparam int DEPTH = RD_LATENCY + 1;
  localparam int FCW = clog2(DEPTH + 1);
  localparam int CW = FCW + 1;
  logic [1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0] remain_q, remain_d;
  logic [RD_LATENCY-1:0] tag_v_q, tag_v_d, tag_l_q, tag_l_d;
  logic done_q, done_d;
  logic accept, issue, issue_last, push, pop, fifo_empty;
  logic [CW-1:0] inflight, credit;
  logic [FCW-1:0] fifo_cnt;
  logic [DATA_WIDTH:0] fifo_dout;
  // a word leaving the FIFO this cycle frees its slot for a read issued now
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(tag_v_q[i]);
    credit = CW'(DEPTH) - CW'(fifo_cnt) - inflight + CW'(pop);
  end
  always_comb begin
    accept = cmd_valid && (state_q == IDLE);
    issue = (accept && cmd_len != '0) || (state_q == ISSUE && credit != '0);
    issue_last = accept ? (cmd_len == 1) : (remain_q == 1);
    state_d = state_q;
    addr_d = issue ? ram_rd_addr + 1'b1 : addr_q;
    remain_d = issue ? (accept ? cmd_len : remain_q) - 1'b1 : remain_q;
    if (issue) state_d = issue_last ? DRAIN : ISSUE;
    else if (state_q == DRAIN && pop && m_last) state_d = IDLE;
    tag_v_d = RD_LATENCY'({tag_v_q, issue});
    tag_l_d = RD_LATENCY'({tag_l_q, issue && issue_last});
    done_d = (accept && cmd_len == '0) || (pop && m_last);
  end
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      tag_v_q <= '0;
      tag_l_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      remain_q <= remain_d;
      tag_v_q <= tag_v_d;
      tag_l_q <= tag_l_d;
      done_q <= done_d;
    end
  end
  // the first read goes out in the accept cycle straight from the command address
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy = (state_q != IDLE);
    ram_rd_addr = accept ? cmd_addr : addr_q;
    push = tag_v_q[RD_LATENCY-1];
    m_valid = !fifo_empty;
    m_data = fifo_dout[DATA_WIDTH-1:0];
    m_last = fifo_dout[DATA_WIDTH];
    pop = m_valid && m_ready;
    done = done_q;
  end
  drm_rd_skid_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk(rd_clk),
    .rst(rd_rst),
    .push(push),
    .pop(pop),
    .din({tag_l_q[RD_LATENCY-1], ram_rd_data}),
    .dout(fifo_dout),
    .count(fifo_cnt),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_drm_stream_reader.sv
// tb_drm_stream_reader: directed tests for the DRM stream reader at read latencies 1 and 2
module tb_drm_stream_reader;
  logic clk = 1'b0;
  logic rst;
  logic cmd_valid [2], cmd_ready [2], m_valid [2], m_ready [2], m_last [2], busy [2], done [2];
  logic [11:0] cmd_addr [2], ram_rd_addr [2];
  logic [12:0] cmd_len [2];
  logic [7:0] ram_rd_data [2], m_data [2];
  logic [7:0] got_d [$];
  logic got_l [$];
  int first_lat, last_pop, done_cyc, done_cnt, stall_err;
  int pass_cnt = 0, chk_cnt = 0;
  always #5 clk = ~clk;
  // RAM contents mix the upper address bits in so wrapped or repeated addresses are visible
  function automatic logic [7:0] ram_f(input logic [11:0] a);
    return a[7:0] ^ {4'h0, a[11:8]};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gen_u
    logic [7:0] p1, p2;
    int ovf = 0;
    drm_stream_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .RD_LATENCY(g + 1)) dut (
      .rd_clk(clk), .rd_rst(rst), .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_addr(cmd_addr[g]), .cmd_len(cmd_len[g]), .ram_rd_addr(ram_rd_addr[g]),
      .ram_rd_data(ram_rd_data[g]), .m_valid(m_valid[g]), .m_ready(m_ready[g]),
      .m_data(m_data[g]), .m_last(m_last[g]), .busy(busy[g]), .done(done[g])
    );
    always @(posedge clk) begin
      p1 <= ram_f(ram_rd_addr[g]);
      p2 <= p1;
      if (dut.push && !dut.pop && dut.fifo_cnt == 2'(g + 2)) ovf <= ovf + 1;
    end
    assign ram_rd_data[g] = (g == 0) ? p1 : p2;
  end
  task automatic run_burst(input int u, input logic [11:0] a, input logic [12:0] n, input bit toggle, input int maxc);
    logic held, hl;
    logic [7:0] hd;
    got_d.delete();
    got_l.delete();
    first_lat = -1; last_pop = -1; done_cyc = -1; done_cnt = 0; stall_err = 0;
    held = 1'b0; hl = 1'b0; hd = '0;
    cmd_valid[u] = 1'b1; cmd_addr[u] = a; cmd_len[u] = n; m_ready[u] = 1'b1;
    @(negedge clk);
    cmd_valid[u] = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      if (done[u]) begin done_cnt++; done_cyc = k; end
      if (m_valid[u] && first_lat < 0) first_lat = k;
      if (held && (!m_valid[u] || m_data[u] !== hd || m_last[u] !== hl)) stall_err++;
      m_ready[u] = toggle ? (k % 2 == 1) : 1'b1;
      if (m_valid[u] && m_ready[u]) begin
        got_d.push_back(m_data[u]);
        got_l.push_back(m_last[u]);
        last_pop = k;
      end
      held = m_valid[u] && !m_ready[u]; hd = m_data[u]; hl = m_last[u];
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
      @(negedge clk);
    end
    m_ready[u] = 1'b1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk_cnt++;
      if ({cmd_ready[u], ram_rd_addr[u], m_valid[u], m_data[u], m_last[u], busy[u], done[u]} !== {1'b1, 12'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0})
        $display("FAIL reset_vals u%0d: got rdy=%b addr=%h v=%b d=%h l=%b busy=%b done=%b expected rdy=1 rest 0", u,
                 cmd_ready[u], ram_rd_addr[u], m_valid[u], m_data[u], m_last[u], busy[u], done[u]);
      else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic(input int u);
    logic [3:0] lv;
    run_burst(u, 12'h010, 13'd4, 1'b0, 40);
    chk_cnt++; if (got_d.size() != 4) $display("FAIL basic_count u%0d: got %0d expected 4", u, got_d.size()); else pass_cnt++;
    lv = '0;
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      lv[i] = got_l[i];
      chk_cnt++;
      if (got_d[i] !== 8'(8'h10 + i)) $display("FAIL basic_data[%0d] u%0d: got %h expected %h", i, u, got_d[i], 8'(8'h10 + i));
      else pass_cnt++;
    end
    chk_cnt++; if (lv !== 4'b1000) $display("FAIL basic_last u%0d: got %b expected 1000", u, lv); else pass_cnt++;
    chk_cnt++; if (first_lat != u + 2) $display("FAIL basic_latency u%0d: got %0d expected %0d", u, first_lat, u + 2); else pass_cnt++;
    chk_cnt++; if (last_pop - first_lat != 3) $display("FAIL basic_throughput u%0d: got span %0d expected 3", u, last_pop - first_lat); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1 || done_cyc != last_pop + 1)
      $display("FAIL basic_done u%0d: got cnt=%0d cyc=%0d expected cnt=1 cyc=%0d", u, done_cnt, done_cyc, last_pop + 1);
    else pass_cnt++;
  endtask
  task automatic test_backpressure(input int u);
    logic [7:0] lv;
    int bad;
    run_burst(u, 12'h020, 13'd8, 1'b1, 80);
    chk_cnt++; if (got_d.size() != 8) $display("FAIL bp_count u%0d: got %0d expected 8", u, got_d.size()); else pass_cnt++;
    lv = '0; bad = 0;
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      lv[i] = got_l[i];
      if (got_d[i] !== 8'(8'h20 + i)) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL bp_order u%0d: got %0d wrong words expected 0", u, bad); else pass_cnt++;
    chk_cnt++; if (lv !== 8'h80) $display("FAIL bp_last u%0d: got %b expected 10000000", u, lv); else pass_cnt++;
    chk_cnt++; if (stall_err != 0) $display("FAIL bp_stable u%0d: got %0d changes while stalled expected 0", u, stall_err); else pass_cnt++;
    chk_cnt++;
    if ((u == 0 ? gen_u[0].ovf : gen_u[1].ovf) != 0) $display("FAIL bp_overflow u%0d: got overflow pushes expected none", u);
    else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL bp_done u%0d: got %0d pulses expected 1", u, done_cnt); else pass_cnt++;
  endtask
  task automatic test_wrap;
    logic [31:0] dv;
    logic [3:0] lv;
    run_burst(0, 12'hFFE, 13'd4, 1'b0, 40);
    dv = '0; lv = '0;
    for (int i = 0; i < got_d.size() && i < 4; i++) begin dv[31-8*i -: 8] = got_d[i]; lv[i] = got_l[i]; end
    chk_cnt++; if (got_d.size() != 4 || dv !== 32'hF1F00001) $display("FAIL wrap_data: got n=%0d %h expected n=4 f1f00001", got_d.size(), dv); else pass_cnt++;
    chk_cnt++; if (lv !== 4'b1000) $display("FAIL wrap_last: got %b expected 1000", lv); else pass_cnt++;
  endtask
  task automatic test_len0;
    run_burst(0, 12'h123, 13'd0, 1'b0, 20);
    chk_cnt++; if (done_cnt != 1 || done_cyc != 1) $display("FAIL len0_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=1", done_cnt, done_cyc); else pass_cnt++;
    chk_cnt++; if (first_lat != -1 || got_d.size() != 0) $display("FAIL len0_novalid: got first=%0d n=%0d expected -1 0", first_lat, got_d.size()); else pass_cnt++;
  endtask
  task automatic test_full;
    int bad, nl;
    run_burst(0, 12'h000, 13'd4096, 1'b0, 4200);
    chk_cnt++; if (got_d.size() != 4096) $display("FAIL full_count: got %0d expected 4096", got_d.size()); else pass_cnt++;
    bad = 0; nl = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== ram_f(12'(i))) bad++;
      if (got_l[i]) nl++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL full_data: got %0d wrong words expected 0", bad); else pass_cnt++;
    chk_cnt++; if (nl != 1 || got_l.size() != 4096 || !got_l[got_l.size() - 1]) $display("FAIL full_last: got %0d lasts expected 1 at end", nl); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL full_done: got %0d expected 1", done_cnt); else pass_cnt++;
  endtask
  task automatic test_reset_mid;
    int pops, seen;
    logic [31:0] dv;
    pops = 0; seen = 0;
    cmd_valid[0] = 1'b1; cmd_addr[0] = 12'h040; cmd_len[0] = 13'd8; m_ready[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    for (int k = 0; k < 20 && pops < 3; k++) begin
      if (m_valid[0] && m_ready[0]) pops++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({cmd_ready[0], ram_rd_addr[0], m_valid[0], m_data[0], m_last[0], busy[0], done[0]} !== {1'b1, 12'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL midrst_vals: got rdy=%b addr=%h v=%b d=%h l=%b busy=%b done=%b expected rdy=1 rest 0",
               cmd_ready[0], ram_rd_addr[0], m_valid[0], m_data[0], m_last[0], busy[0], done[0]);
    else pass_cnt++;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done[0] || m_valid[0] || busy[0]) seen++;
    end
    chk_cnt++; if (seen != 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen); else pass_cnt++;
    run_burst(0, 12'h050, 13'd4, 1'b0, 40);
    dv = '0;
    for (int i = 0; i < got_d.size() && i < 4; i++) dv[31-8*i -: 8] = got_d[i];
    chk_cnt++; if (got_d.size() != 4 || dv !== 32'h50515253) $display("FAIL midrst_rerun: got n=%0d %h expected n=4 50515253", got_d.size(), dv); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL midrst_done: got %0d expected 1", done_cnt); else pass_cnt++;
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_addr[u] = '0; cmd_len[u] = '0; m_ready[u] = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic(0);
    test_basic(1);
    test_backpressure(0);
    test_backpressure(1);
    test_wrap();
    test_len0();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
